// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_fa4.sv
// 4-bit binary full-adder stage driven by nibble_serial_adder; lives beside it, not inside.
module nibble_serial_adder_fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {4'd0, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial controller around an external 4-bit adder stage: feeds one nibble
// per clock LSN first, chains the carry, and assembles the wide sum.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                cout,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_ci,
  input  logic [NIBBLE_W-1:0] add_sum,
  input  logic                add_co
);

  localparam int                IDX_W    = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            carry  <= cin;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          // Sum nibbles enter at the top so the LSN lands at bit 0 after NIBBLES edges.
          res_sh <= {add_sum, res_sh[WIDTH-1:NIBBLE_W]};
          carry  <= add_co;
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == ADD) begin
      add_a  = a_sh[NIBBLE_W-1:0];
      add_b  = b_sh[NIBBLE_W-1:0];
      add_ci = carry;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_sh;
  assign cout   = carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES=4 and NIBBLES=2, each wired to a 4-bit adder stage.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start4, cin4, busy4, done4, cout4;
  logic [15:0] a4, b4, res4;
  logic [3:0]  aa4, ab4, as4;
  logic        aci4, aco4;

  logic        start2, cin2, busy2, done2, cout2;
  logic [7:0]  a2, b2, res2;
  logic [3:0]  aa2, ab2, as2;
  logic        aci2, aco2;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_a(a4), .op_b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4),
    .add_a(aa4), .add_b(ab4), .add_ci(aci4), .add_sum(as4), .add_co(aco4)
  );
  nibble_serial_adder_fa4 fa4 (.a(aa4), .b(ab4), .ci(aci4), .sum(as4), .co(aco4));

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(a2), .op_b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .result(res2), .cout(cout2),
    .add_a(aa2), .add_b(ab2), .add_ci(aci2), .add_sum(as2), .add_co(aco2)
  );
  nibble_serial_adder_fa4 fa2 (.a(aa2), .b(ab2), .ci(aci2), .sum(as2), .co(aco2));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  logic [16:0] q4[$];
  logic [8:0]  q2[$];
  logic [16:0] e4;
  logic [8:0]  e2;

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (q4.size() == 0) fail("done4_unexpected");
      else begin
        e4 = q4.pop_front();
        check("result4", {15'd0, cout4, res4}, {15'd0, e4});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) fail("done2_unexpected");
      else begin
        e2 = q2.pop_front();
        check("result2", {23'd0, cout2, res2}, {23'd0, e2});
      end
    end
  end

  logic [3:0] seq_a[8];
  logic       seq_ci[8];
  int         lat;

  task automatic wait_done4();
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        seq_a[n-1]  = aa4;
        seq_ci[n-1] = aci4;
      end
      if (done4) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) fail("done4_timeout");
    else check("latency4", lat, 5);
  endtask

  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    q4.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
    @(posedge clk);
    #1 start4 = 1'b0;
    wait_done4();
    @(negedge clk);
  endtask

  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic c);
    int l;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
    @(posedge clk);
    #1 start2 = 1'b0;
    l = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done2) begin
        l = n;
        break;
      end
    end
    if (l == 0) fail("done2_timeout");
    else check("latency2", l, 3);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int dones;

  initial begin
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", res4, 0);
    check("rst_cout", cout4, 0);
    check("rst_add_pins", {aa4, ab4, aci4}, 0);
    rst = 1'b0;

    op4(16'h1234, 16'h4321, 1'b0);
    check("seq_a0", seq_a[0], 4);
    check("seq_a1", seq_a[1], 3);
    check("seq_a2", seq_a[2], 2);
    check("seq_a3", seq_a[3], 1);

    op4(16'hFFFF, 16'h0001, 1'b0);
    check("seq_ci0", seq_ci[0], 0);
    check("seq_ci1", seq_ci[1], 1);
    check("seq_ci2", seq_ci[2], 1);
    check("seq_ci3", seq_ci[3], 1);
    check("idle_add_pins", {aa4, ab4, aci4}, 0);
    check("hold_result", {cout4, res4}, 17'h10000);

    op4(16'h0000, 16'h0000, 1'b1);
    op4(16'hFFFF, 16'hFFFF, 1'b1);

    // start held high, operands changed mid-operation.
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
    q4.push_back(17'h03333);
    @(posedge clk);
    #1;
    a4 = 16'h0F0F; b4 = 16'h0101; cin4 = 1'b1;
    repeat (5) @(negedge clk);
    check("held_done", done4, 1);
    @(negedge clk);
    check("held_idle_busy", busy4, 0);
    check("held_done_pulse", done4, 0);
    q4.push_back(17'h01011);
    @(posedge clk);
    #1;
    check("held_reaccept", busy4, 1);
    start4 = 1'b0;
    wait_done4();
    @(negedge clk);

    // Reset in the 3rd ADD cycle aborts without a done pulse.
    @(negedge clk);
    a4 = 16'h8888; b4 = 16'h8888; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_result", {cout4, res4}, 0);
    check("abort_add_pins", {aa4, ab4, aci4}, 0);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("abort_no_done", dones, 0);
    op4(16'h8888, 16'h8888, 1'b0);

    op2(8'hFF, 8'h01, 1'b0);
    op2(8'h5A, 8'hA5, 1'b1);
    op2(8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 1000; i++)
      op4(16'($urandom), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 1000; i++)
      op2(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    check("q4_drained", q4.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
